// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pong_pkg
//  Brief    : Shared constants and helpers for the encoder input conditioning
//  Revision : 1.0  initial release
// ============================================================================
package pong_pkg;

  // Consecutive sample ticks a new level must persist before it is accepted
  localparam int DEBOUNCE_STABLE_DEFAULT = 4;
  // Metastability synchroniser depth
  localparam int SYNC_STAGES_DEFAULT     = 2;
  // Encoder pins: A and B quadrature
  localparam int ENC_CHANNELS            = 2;

  // Width of a counter able to hold 0..stable
  function automatic int cnt_width(input int stable);
    return (stable < 1) ? 1 : $clog2(stable + 1);
  endfunction

endpackage : pong_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Brief    : One-bit synchroniser + stability filter with rise/fall strobes
//  Revision : 1.0  initial release
// ============================================================================
module debounce_channel
  import pong_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s_w;

  // Synchronised level seen by the filter is the last shift stage
  assign s_w = sync_q[SYNC_STAGES-1];

  // Next-state: shift synchroniser every clock; count only disagreeing ticks
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s_w == clean_q) begin
      // Bounce back to the accepted level: discard progress regardless of tick
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = s_w;
        cnt_d   = '0;
        rise_d  = s_w;
        fall_d  = ~s_w;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; reset drops any pending transition without a strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/quad_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : quad_input_debouncer
//  Brief    : Per-pin synchronise and debounce of rotary-encoder inputs
//  Revision : 1.0  initial release
// ============================================================================
module quad_input_debouncer
  import pong_pkg::*;
#(
  parameter int CHANNELS      = ENC_CHANNELS,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEFAULT,
  parameter int STABLE_CYCLES = DEBOUNCE_STABLE_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [CHANNELS-1:0] raw,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  // Channels are fully independent, one filter per pin
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick_i  (tick),
      .raw_i   (raw[g]),
      .clean_o (clean[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g])
    );
  end : g_ch

endmodule : quad_input_debouncer
`default_nettype wire
